// File: rtl/mtrx_pkg.sv
// mtrx_pkg: register map, command/status bit positions and fill FSM encodings
// shared by the matrix write scheduler. Rev 1.0
`default_nettype none

package mtrx_pkg;

  localparam logic [15:0] REG_FRONT      = 16'd2048;
  localparam logic [15:0] REG_FILL_COLOR = 16'd2049;
  localparam logic [15:0] REG_CMD        = 16'd2050;
  localparam logic [15:0] REG_STATUS     = 16'd2051;

  localparam int CMD_FILL_BIT  = 0;
  localparam int CMD_SWAP_BIT  = 1;

  localparam int ST_BUSY_BIT   = 0;
  localparam int ST_SWAP_BIT   = 1;
  localparam int ST_FRONT_BIT  = 2;

  localparam logic [0:0] FSM_IDLE = 1'b0;
  localparam logic [0:0] FSM_FILL = 1'b1;

  typedef logic [11:0] rgb444_t;

  function automatic logic [15:0] status_word(input logic busy, input logic pend,
                                              input logic front);
    logic [15:0] w;
    w               = '0;
    w[ST_BUSY_BIT]  = busy;
    w[ST_SWAP_BIT]  = pend;
    w[ST_FRONT_BIT] = front;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mtrx_fill_engine.sv
// mtrx_fill_engine: walks a word index 0..FB_WORDS-1, one word per non-stalled
// cycle, and flags the cycle the last word is issued. Rev 1.0
`default_nettype none

module mtrx_fill_engine
  import mtrx_pkg::*;
#(
  parameter int FB_WORDS = 1024
) (
  input  logic                        clk100,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_stall,
  output logic                        o_busy,
  output logic                        o_issue,
  output logic [$clog2(FB_WORDS)-1:0] o_idx,
  output logic                        o_done
);

  localparam int IDX_W = $clog2(FB_WORDS);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             w_last;

  assign w_last  = (r_idx == IDX_W'(FB_WORDS - 1));
  assign o_busy  = (r_state == FSM_FILL);
  assign o_issue = o_busy && !i_stall;
  assign o_done  = o_issue && w_last;
  assign o_idx   = r_idx;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FSM_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        FSM_IDLE: begin
          r_idx <= '0;
          if (i_start) r_state <= FSM_FILL;
        end
        FSM_FILL: begin
          // A stalled cycle keeps the index so no word is skipped or repeated
          if (o_issue) begin
            if (w_last) begin
              r_state <= FSM_IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= FSM_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mtrx_wr_sched.sv
// mtrx_wr_sched: arbitrates host pixel writes against buffer fills onto the
// matrix write port and manages front-buffer swaps at frame boundaries. Rev 1.0
`default_nettype none

module mtrx_wr_sched
  import mtrx_pkg::*;
#(
  parameter int FB_WORDS = 1024,
  parameter int ADDR_W   = 11
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              sb_wr,
  input  logic              sb_rd,
  input  logic [15:0]       sb_addr,
  input  logic [15:0]       sb_wr_data,
  output logic [15:0]       sb_rd_data,
  input  logic              frame_start,
  output logic              mtrx_wr,
  output logic [ADDR_W-1:0] mtrx_wr_addr,
  output logic [11:0]       mtrx_wr_data,
  output logic              front,
  output logic              irq
);

  localparam int          IDX_W   = $clog2(FB_WORDS);
  localparam logic [15:0] PIX_END = 16'(2 * FB_WORDS);

  logic              w_pix_wr, w_front_wr, w_color_wr, w_cmd_wr;
  logic              w_fill_req, w_swap_req, w_start;
  logic              w_busy, w_issue, w_done;
  logic              w_swap_evt, w_swap_do;
  logic [IDX_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [15:0]       w_rd_val;
  logic              w_unused;

  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  rgb444_t           r_data;
  logic              r_front;
  logic              r_swap_pend;
  rgb444_t           r_fill_color;
  rgb444_t           r_fill_lat;
  logic              r_fill_buf;
  logic              r_irq;
  logic [15:0]       r_rd_data;

  assign w_pix_wr   = sb_wr && (sb_addr < PIX_END);
  assign w_front_wr = sb_wr && (sb_addr == REG_FRONT);
  assign w_color_wr = sb_wr && (sb_addr == REG_FILL_COLOR);
  assign w_cmd_wr   = sb_wr && (sb_addr == REG_CMD);
  assign w_fill_req = w_cmd_wr && sb_wr_data[CMD_FILL_BIT];
  assign w_swap_req = w_cmd_wr && sb_wr_data[CMD_SWAP_BIT];
  assign w_start    = w_fill_req && !w_busy;

  // A swap may not coincide with a fill start, or the fill would target the new front
  assign w_swap_evt = frame_start && r_swap_pend && !w_busy && !w_start;
  assign w_swap_do  = w_swap_evt && !w_front_wr;

  assign w_fill_addr = ADDR_W'({r_fill_buf, w_idx});
  assign w_unused    = ^sb_wr_data[15:12];

  mtrx_fill_engine #(
    .FB_WORDS (FB_WORDS)
  ) u_fill (
    .clk100  (clk100),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_stall (w_pix_wr),
    .o_busy  (w_busy),
    .o_issue (w_issue),
    .o_idx   (w_idx),
    .o_done  (w_done)
  );

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wr <= w_pix_wr || w_issue;
      if (w_pix_wr) begin
        r_addr <= sb_addr[ADDR_W-1:0];
        r_data <= sb_wr_data[11:0];
      end else if (w_issue) begin
        r_addr <= w_fill_addr;
        r_data <= r_fill_lat;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_front      <= 1'b0;
      r_swap_pend  <= 1'b0;
      r_fill_color <= '0;
      r_fill_lat   <= '0;
      r_fill_buf   <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_irq <= w_done || w_swap_do;

      if (w_color_wr) r_fill_color <= sb_wr_data[11:0];

      if (w_start) begin
        r_fill_lat <= r_fill_color;
        r_fill_buf <= ~r_front;
      end

      if (w_front_wr)     r_front <= sb_wr_data[0];
      else if (w_swap_do) r_front <= ~r_front;

      // A swap event consumes the pending request even when a FRONT write overrides it
      if (w_swap_evt)      r_swap_pend <= 1'b0;
      else if (w_swap_req) r_swap_pend <= 1'b1;
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (sb_addr)
      REG_FRONT:      w_rd_val = {15'd0, r_front};
      REG_FILL_COLOR: w_rd_val = {4'd0, r_fill_color};
      REG_STATUS:     w_rd_val = status_word(w_busy, r_swap_pend, r_front);
      default:        w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)     r_rd_data <= '0;
    else if (sb_rd) r_rd_data <= w_rd_val;
  end

  assign sb_rd_data   = r_rd_data;
  assign mtrx_wr      = r_wr;
  assign mtrx_wr_addr = r_addr;
  assign mtrx_wr_data = r_data;
  assign front        = r_front;
  assign irq          = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mtrx_wr_sched.sv
// tb_mtrx_wr_sched: scoreboard bench for mtrx_wr_sched (host writes, fills,
// swaps, register access, reset mid-fill). Rev 1.0
`default_nettype none

module tb_mtrx_wr_sched;

  localparam int FB = 1024;
  localparam logic [15:0] A_FRONT  = 16'd2048;
  localparam logic [15:0] A_COLOR  = 16'd2049;
  localparam logic [15:0] A_CMD    = 16'd2050;
  localparam logic [15:0] A_STATUS = 16'd2051;

  logic        clk100 = 1'b0;
  logic        rst_n;
  logic        sb_wr, sb_rd, frame_start;
  logic [15:0] sb_addr, sb_wr_data, sb_rd_data;
  logic        mtrx_wr, front, irq;
  logic [10:0] mtrx_wr_addr;
  logic [11:0] mtrx_wr_data;

  mtrx_wr_sched #(.FB_WORDS(FB), .ADDR_W(11)) dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .sb_wr        (sb_wr),
    .sb_rd        (sb_rd),
    .sb_addr      (sb_addr),
    .sb_wr_data   (sb_wr_data),
    .sb_rd_data   (sb_rd_data),
    .frame_start  (frame_start),
    .mtrx_wr      (mtrx_wr),
    .mtrx_wr_addr (mtrx_wr_addr),
    .mtrx_wr_data (mtrx_wr_data),
    .front        (front),
    .irq          (irq)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    logic [10:0] a;
    logic [11:0] d;
    int          due;
  } hw_t;

  hw_t         hq[$];
  int          irq_q[$];
  int          fq[$];
  int          fsq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        fill_active = 1'b0;
  int          fill_next, fill_base, first_fill, last_fill, hosts_during;
  logic [11:0] fill_color, exp_color;
  logic        exp_front, prev_front;
  logic [15:0] rv;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: host writes are due at a known cycle; any other write must be the next fill word
  always @(posedge clk100) begin
    cyc++;
    #1;
    if (!rst_n) begin
      prev_front = front;
    end else begin
      if (hq.size() > 0 && hq[0].due == cyc) begin
        hw_t e;
        e = hq.pop_front();
        check_val("host_wr", {31'd0, mtrx_wr}, 32'd1);
        check_val("host_addr", {21'd0, mtrx_wr_addr}, {21'd0, e.a});
        check_val("host_data", {20'd0, mtrx_wr_data}, {20'd0, e.d});
        if (fill_active && fill_next > 0) hosts_during++;
      end else if (mtrx_wr) begin
        if (fill_active) begin
          check_val("fill_addr", {21'd0, mtrx_wr_addr}, fill_base + fill_next);
          check_val("fill_data", {20'd0, mtrx_wr_data}, {20'd0, fill_color});
          if (fill_next == 0) first_fill = cyc;
          fill_next++;
          if (fill_next == FB) begin
            fill_active = 1'b0;
            last_fill   = cyc;
          end
        end else begin
          check_val("spurious_wr", {21'd0, mtrx_wr_addr}, 32'hFFFF_FFFF);
        end
      end
      if (irq) irq_q.push_back(cyc);
      if (front !== prev_front) begin
        fq.push_back(cyc);
        prev_front = front;
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk100);
    sb_wr = 1'b1; sb_addr = a; sb_wr_data = d;
    if (a < 16'd2048) hq.push_back('{a[10:0], d[11:0], cyc + 1});
    @(negedge clk100);
    sb_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk100);
    sb_rd = 1'b1; sb_addr = a;
    @(negedge clk100);
    sb_rd = 1'b0;
    v = sb_rd_data;
  endtask

  task automatic cmd(input logic [15:0] d);
    if (d[0] && !fill_active) begin
      fill_active  = 1'b1;
      fill_next    = 0;
      hosts_during = 0;
      fill_base    = exp_front ? 0 : FB;
      fill_color   = exp_color;
    end
    wr(A_CMD, d);
  endtask

  task automatic wait_fill();
    int k;
    k = 0;
    while (fill_active && k < 3000) begin
      @(negedge clk100);
      k++;
    end
    check_val("fill_done", {31'd0, fill_active}, 32'd0);
  endtask

  initial begin
    int exp_tog;
    rst_n = 1'b0; sb_wr = 1'b0; sb_rd = 1'b0; frame_start = 1'b0;
    sb_addr = '0; sb_wr_data = '0;
    exp_front = 1'b0; exp_color = '0; prev_front = 1'b0;
    repeat (3) @(negedge clk100);
    check_val("rst_mtrx_wr", {31'd0, mtrx_wr}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_front", {31'd0, front}, 32'd0);
    check_val("rst_rd_data", {16'd0, sb_rd_data}, 32'd0);
    rst_n = 1'b1;
    rd(A_STATUS, rv);     check_val("rst_status", {16'd0, rv}, 32'd0);
    rd(A_COLOR, rv);      check_val("rst_color", {16'd0, rv}, 32'd0);

    // Host pixel writes and register decode
    wr(16'd5, 16'h0ABC);
    wr(16'd2047, 16'hFFFF);
    wr(16'd1024, 16'h0123);
    wr(16'd3000, 16'h5555);
    rd(16'd3000, rv);     check_val("unmapped_rd", {16'd0, rv}, 32'd0);
    wr(A_FRONT, 16'h0001);
    check_val("front_wr", {31'd0, front}, 32'd1);
    rd(A_FRONT, rv);      check_val("front_rd", {16'd0, rv}, 32'd1);
    wr(A_FRONT, 16'h0000);
    wr(A_COLOR, 16'h00F0); exp_color = 12'h0F0;
    rd(A_COLOR, rv);      check_val("color_rd", {16'd0, rv}, 32'h0F0);
    rd(A_CMD, rv);        check_val("cmd_rd", {16'd0, rv}, 32'd0);

    // Plain fill; colour change and a second start mid-fill must not disturb it
    irq_q.delete();
    cmd(16'h0001);
    wr(A_COLOR, 16'h0123); exp_color = 12'h123;
    cmd(16'h0001);
    rd(A_STATUS, rv);     check_val("status_busy", {16'd0, rv}, 32'h0001);
    wait_fill();
    repeat (3) @(negedge clk100);
    check_val("fill_irq_n", irq_q.size(), 32'd1);
    if (irq_q.size() > 0)
      check_val("fill_irq_cyc", {31'd0, (irq_q[0] == last_fill || irq_q[0] == last_fill + 1)}, 32'd1);
    rd(A_STATUS, rv);     check_val("status_idle", {16'd0, rv}, 32'd0);

    // Fill with a host write every third cycle
    cmd(16'h0001);
    for (int i = 0; i < 4000 && fill_active; i++) begin
      @(negedge clk100);
      if (i % 3 == 0) begin
        sb_wr = 1'b1; sb_addr = 16'(100 + i / 3); sb_wr_data = 16'(i);
        hq.push_back('{sb_addr[10:0], sb_wr_data[11:0], cyc + 1});
      end else begin
        sb_wr = 1'b0;
      end
    end
    @(negedge clk100); sb_wr = 1'b0;
    check_val("fill_done_stall", {31'd0, fill_active}, 32'd0);
    check_val("fill_span", last_fill - first_fill + 1, FB + hosts_during);
    repeat (3) @(negedge clk100);
    check_val("host_q_empty", hq.size(), 32'd0);

    // Fill plus swap request, frame_start every 200 cycles
    irq_q.delete(); fq.delete(); fsq.delete();
    cmd(16'h0003);
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk100);
      frame_start = (i % 200 == 199);
      if (frame_start) fsq.push_back(cyc + 1);
    end
    @(negedge clk100); frame_start = 1'b0;
    exp_tog = -1;
    foreach (fsq[j]) if (exp_tog < 0 && fsq[j] > last_fill) exp_tog = fsq[j];
    check_val("swap_toggles", fq.size(), 32'd1);
    if (fq.size() > 0) check_val("swap_cyc", fq[0], exp_tog);
    check_val("swap_irq_n", irq_q.size(), 32'd2);
    if (irq_q.size() == 2) check_val("swap_irq_cyc", irq_q[1], exp_tog);
    exp_front = 1'b1;
    check_val("front_after_swap", {31'd0, front}, {31'd0, exp_front});

    // Two merged requests give one toggle
    fq.delete();
    cmd(16'h0002);
    cmd(16'h0002);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk100); frame_start = 1'b1;
      if (p == 0) exp_tog = cyc + 1;
      @(negedge clk100); frame_start = 1'b0;
      repeat (5) @(negedge clk100);
    end
    check_val("merge_toggles", fq.size(), 32'd1);
    if (fq.size() > 0) check_val("merge_cyc", fq[0], exp_tog);
    exp_front = 1'b0;
    rd(A_STATUS, rv);     check_val("merge_status", {16'd0, rv}, 32'd0);

    // FRONT write coincident with a swap event
    fq.delete();
    cmd(16'h0002);
    rd(A_STATUS, rv);     check_val("pend_set", {16'd0, rv}, 32'h0002);
    @(negedge clk100);
    sb_wr = 1'b1; sb_addr = A_FRONT; sb_wr_data = 16'h0000; frame_start = 1'b1;
    @(negedge clk100);
    sb_wr = 1'b0; frame_start = 1'b0;
    check_val("front_wins", {31'd0, front}, 32'd0);
    rd(A_STATUS, rv);     check_val("pend_cleared", {16'd0, rv}, 32'd0);
    @(negedge clk100); frame_start = 1'b1;
    @(negedge clk100); frame_start = 1'b0;
    repeat (3) @(negedge clk100);
    check_val("no_late_swap", fq.size(), 32'd0);

    // Reset at fill word 500
    wr(A_FRONT, 16'h0001); exp_front = 1'b1;
    cmd(16'h0001);
    for (int k = 0; k < 2000 && fill_next < 500; k++) @(negedge clk100);
    check_val("reached_500", {31'd0, fill_next >= 500}, 32'd1);
    rst_n = 1'b0;
    fill_active = 1'b0;
    hq.delete();
    #1;
    check_val("mid_rst_wr", {31'd0, mtrx_wr}, 32'd0);
    check_val("mid_rst_addr", {21'd0, mtrx_wr_addr}, 32'd0);
    check_val("mid_rst_data", {20'd0, mtrx_wr_data}, 32'd0);
    check_val("mid_rst_front", {31'd0, front}, 32'd0);
    check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk100);
    rst_n = 1'b1; exp_front = 1'b0; exp_color = '0;
    repeat (50) @(negedge clk100);
    rd(A_STATUS, rv);     check_val("post_rst_status", {16'd0, rv}, 32'd0);
    rd(A_COLOR, rv);      check_val("post_rst_color", {16'd0, rv}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
